// File: rtl/param_mux_rr_reg.sv
// CHANNELS-input, WIDTH-bit multiplexer with a registered output, selected either
// externally (mode=0) or by round-robin arbitration among valid channels (mode=1).
module param_mux_rr_reg #(
    parameter  int WIDTH    = 2,
    parameter  int CHANNELS = 2,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic                      hold,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid_out,
    output logic [SEL_W-1:0]          chan_out
);

    logic [SEL_W-1:0] ptr;

    logic [WIDTH-1:0] ext_data;
    logic             ext_valid;

    logic             rr_found;
    logic [WIDTH-1:0] rr_data;
    logic [SEL_W-1:0] rr_chan;
    logic [SEL_W-1:0] rr_next;

    // An out-of-range sel_in matches no channel, so it yields zero data and no valid.
    always_comb begin : ext_select
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        ext_data  = '0;
        ext_valid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_in == SEL_W'(k)) begin
                ext_data  = in_data[k*WIDTH +: WIDTH];
                ext_valid = in_valid[k];
            end
        end
    end

    // Walk the channels starting at ptr, wrapping modulo CHANNELS; first valid one wins.
    always_comb begin : rr_search
        logic [SEL_W:0] pos;
        pos      = '0;
        rr_found = 1'b0;
        rr_data  = '0;
        rr_chan  = '0;
        rr_next  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pos = {1'b0, ptr} + (SEL_W+1)'(i);
            if (pos >= (SEL_W+1)'(CHANNELS)) begin
                pos = pos - (SEL_W+1)'(CHANNELS);
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (!rr_found && pos == (SEL_W+1)'(k) && in_valid[k]) begin
                    rr_found = 1'b1;
                    rr_data  = in_data[k*WIDTH +: WIDTH];
                    rr_chan  = SEL_W'(k);
                    rr_next  = (k == CHANNELS-1) ? '0 : SEL_W'(k+1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            chan_out  <= '0;
            ptr       <= '0;
        end else if (!hold) begin
            if (!mode) begin
                data_out  <= ext_data;
                valid_out <= ext_valid;
                chan_out  <= sel_in;
            end else if (rr_found) begin
                data_out  <= rr_data;
                valid_out <= 1'b1;
                chan_out  <= rr_chan;
                ptr       <= rr_next;
            end else begin
                // Idle round-robin cycle: chan_out and ptr keep pointing where they were.
                data_out  <= '0;
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_mux_rr_reg.sv
// Randomised and directed bench for param_mux_rr_reg, run at CHANNELS=4 and CHANNELS=3
// against a behavioural model of the selection rules.
module tb_param_mux_rr_reg;

    logic clk = 1'b0;
    logic reset_L;

    logic       mode4, hold4;
    logic [1:0] sel4;
    logic [7:0] data4;
    logic [3:0] val4;
    logic [1:0] dout4, cout4;
    logic       vout4;

    logic       mode3, hold3;
    logic [1:0] sel3;
    logic [5:0] data3;
    logic [2:0] val3;
    logic [1:0] dout3, cout3;
    logic       vout3;

    typedef struct {
        int data;
        int valid;
        int chan;
        int ptr;
    } mstate_t;

    mstate_t m4, m3;
    int vectors     = 0;
    int miscompares = 0;

    param_mux_rr_reg #(.WIDTH(2), .CHANNELS(4)) dut4 (
        .clk(clk), .reset_L(reset_L), .mode(mode4), .sel_in(sel4), .in_data(data4),
        .in_valid(val4), .hold(hold4), .data_out(dout4), .valid_out(vout4), .chan_out(cout4)
    );

    param_mux_rr_reg #(.WIDTH(2), .CHANNELS(3)) dut3 (
        .clk(clk), .reset_L(reset_L), .mode(mode3), .sel_in(sel3), .in_data(data3),
        .in_valid(val3), .hold(hold3), .data_out(dout3), .valid_out(vout3), .chan_out(cout3)
    );

    always #5 clk = ~clk;

    // Reference behaviour: plain modulo arithmetic over an array of channels.
    function automatic mstate_t ref_step(mstate_t s, int n, bit hold, bit mode, int sel,
                                         int d[4], int v[4]);
        mstate_t r = s;
        if (hold) return r;
        if (!mode) begin
            r.chan  = sel;
            r.data  = (sel < n) ? d[sel] : 0;
            r.valid = (sel < n) ? v[sel] : 0;
        end else begin
            r.data  = 0;
            r.valid = 0;
            for (int i = 0; i < n; i++) begin
                int g = (s.ptr + i) % n;
                if (v[g] != 0) begin
                    r.data  = d[g];
                    r.valid = 1;
                    r.chan  = g;
                    r.ptr   = (g + 1) % n;
                    break;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] pk(mstate_t s);
        logic [4:0] p;
        p = {s.valid[0], s.chan[1:0], s.data[1:0]};
        return p;
    endfunction

    function automatic logic [4:0] got4();
        return {vout4, cout4, dout4};
    endfunction

    function automatic logic [4:0] got3();
        return {vout3, cout3, dout3};
    endfunction

    task automatic zero_models();
        m4 = '{0, 0, 0, 0};
        m3 = '{0, 0, 0, 0};
    endtask

    // One clock: advance both models on the inputs the bench drove, then settle at negedge.
    task automatic tick();
        int d[4];
        int v[4];
        @(posedge clk);
        if (!reset_L) begin
            zero_models();
        end else begin
            for (int k = 0; k < 4; k++) begin
                d[k] = int'(data4[k*2 +: 2]);
                v[k] = int'(val4[k]);
            end
            m4 = ref_step(m4, 4, hold4, mode4, int'(sel4), d, v);
            for (int k = 0; k < 3; k++) begin
                d[k] = int'(data3[k*2 +: 2]);
                v[k] = int'(val3[k]);
            end
            d[3] = 0;
            v[3] = 0;
            m3 = ref_step(m3, 3, hold3, mode3, int'(sel3), d, v);
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_L = 1'b0;
        zero_models();
        #1;
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        mode4 = 1'b0; hold4 = 1'b0; sel4 = 2'd0; data4 = 8'hFF; val4 = 4'hF;
        mode3 = 1'b0; hold3 = 1'b0; sel3 = 2'd0; data3 = 6'h3F; val3 = 3'h7;
        zero_models();
        #1;
        vectors++;
        if (got4() !== 5'b0 || got3() !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_initial: got4=%b got3=%b want 00000", got4(), got3());
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (got4() !== 5'b0 || got3() !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_held cycle %0d: got4=%b got3=%b want 00000", i, got4(), got3());
            end
        end
        reset_L = 1'b1;
    endtask

    task automatic test_ext_select();
        mode4 = 1'b0; val4 = 4'b1111; data4 = 8'b11_10_01_00; hold4 = 1'b0;
        for (int s = 0; s < 4; s++) begin
            logic [1:0] sv;
            sv   = 2'(s);
            sel4 = sv;
            tick();
            vectors++;
            if (got4() !== {1'b1, sv, sv} || got4() !== pk(m4)) begin
                miscompares++;
                $display("FAIL ext_select sel=%0d: got=%b want=%b", s, got4(), {1'b1, sv, sv});
            end
        end
    endtask

    task automatic test_async_reset();
        // Outputs are nonzero here (channel 3 selected); reset must clear them between edges.
        @(negedge clk);
        #2;
        reset_L = 1'b0;
        zero_models();
        #1;
        vectors++;
        if (got4() !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset: got=%b want=00000 before any edge", got4());
        end
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_rr_all();
        int seq[5] = '{0, 1, 2, 3, 0};
        mode4 = 1'b1; val4 = 4'b1111; data4 = 8'b11_10_01_00; hold4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] c;
            c = 2'(seq[i]);
            tick();
            vectors++;
            if (got4() !== {1'b1, c, c} || got4() !== pk(m4)) begin
                miscompares++;
                $display("FAIL rr_all step %0d: got=%b want=%b", i, got4(), {1'b1, c, c});
            end
        end
    endtask

    task automatic test_rr_sparse();
        int seq[6] = '{1, 3, 1, 3, -1, 1};
        pulse_reset();
        mode4 = 1'b1; data4 = 8'b11_10_01_00; hold4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [4:0] want;
            val4 = (seq[i] < 0) ? 4'b0000 : 4'b1010;
            want = (seq[i] < 0) ? 5'b0_11_00 : {1'b1, 2'(seq[i]), 2'(seq[i])};
            tick();
            vectors++;
            if (got4() !== want || got4() !== pk(m4)) begin
                miscompares++;
                $display("FAIL rr_sparse step %0d: got=%b want=%b", i, got4(), want);
            end
        end
    endtask

    task automatic test_hold();
        logic [4:0] frozen;
        logic [1:0] nxt;
        mode4 = 1'b1; val4 = 4'b1111; data4 = 8'b11_10_01_00; hold4 = 1'b0;
        tick();
        tick();
        frozen = got4();
        hold4  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mode4 = i[0];
            sel4  = 2'($urandom_range(0, 3));
            data4 = 8'($urandom);
            val4  = 4'($urandom);
            tick();
            vectors++;
            if (got4() !== frozen || got4() !== pk(m4)) begin
                miscompares++;
                $display("FAIL hold cycle %0d: got=%b want=%b", i, got4(), frozen);
            end
        end
        hold4 = 1'b0; mode4 = 1'b1; val4 = 4'b1111; data4 = 8'b11_10_01_00;
        nxt = frozen[3:2] + 2'd1;
        tick();
        vectors++;
        if (got4() !== {1'b1, nxt, nxt} || got4() !== pk(m4)) begin
            miscompares++;
            $display("FAIL hold_resume: got=%b want=%b", got4(), {1'b1, nxt, nxt});
        end
    endtask

    task automatic test_three_channels();
        mode3 = 1'b0; hold3 = 1'b0; data3 = 6'b10_01_11; val3 = 3'b111; sel3 = 2'd3;
        tick();
        vectors++;
        if (got3() !== 5'b0_11_00 || got3() !== pk(m3)) begin
            miscompares++;
            $display("FAIL ch3_sel_out_of_range: got=%b want=01100", got3());
        end
        sel3 = 2'd1; val3 = 3'b101;
        tick();
        vectors++;
        if (got3() !== 5'b0_01_01 || got3() !== pk(m3)) begin
            miscompares++;
            $display("FAIL ch3_sel_invalid: got=%b want=00101", got3());
        end
        // Round-robin wrap at CHANNELS=3, continuing from the pointer reset left at 0.
        mode3 = 1'b1; val3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (got3() !== pk(m3) || int'(cout3) != i % 3) begin
                miscompares++;
                $display("FAIL ch3_rr step %0d: got=%b want=%b", i, got3(), pk(m3));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            mode4 = 1'($urandom);
            hold4 = ($urandom_range(0, 4) == 0);
            sel4  = 2'($urandom);
            data4 = 8'($urandom);
            val4  = 4'($urandom) & 4'($urandom);
            mode3 = 1'($urandom);
            hold3 = ($urandom_range(0, 4) == 0);
            sel3  = 2'($urandom);
            data3 = 6'($urandom);
            val3  = 3'($urandom) & 3'($urandom);
            tick();
            vectors++;
            if (got4() !== pk(m4)) begin
                miscompares++;
                $display("FAIL random4 cycle %0d: got=%b want=%b", i, got4(), pk(m4));
            end
            vectors++;
            if (got3() !== pk(m3)) begin
                miscompares++;
                $display("FAIL random3 cycle %0d: got=%b want=%b", i, got3(), pk(m3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ext_select();
        test_async_reset();
        test_rr_all();
        test_rr_sparse();
        test_hold();
        test_three_channels();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_mux_rr_reg.md
Name: param_mux_rr_reg

Overview:
- Parametrised successor to the 2-bit 2:1 mux plus flip-flop pair: a CHANNELS-input, WIDTH-bit multiplexer with a registered output.
- Adds valid qualification, two select modes (external select or internal round-robin arbitration), and a hold/stall control.
- Sits between per-lane data sources and a single downstream registered lane, replacing the hand-built mux-and-flop chains.

Parameters:
- WIDTH, 2, data bits per channel (≥1).
- CHANNELS, 2, number of input channels (≥2).
- SEL_W, $clog2(CHANNELS), width of channel index signals (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  asynchronous, active-low reset.
- mode  input  1  0 = external select via sel_in; 1 = round-robin among valid channels.
- sel_in  input  SEL_W  channel index used when mode=0.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- hold  input  1  1 = freeze all state and outputs.
- data_out  output  WIDTH  registered selected data.
- valid_out  output  1  registered valid for data_out.
- chan_out  output  SEL_W  registered index of the channel driving data_out.

Behaviour:
- Reset (reset_L=0, asynchronous, takes effect immediately without a clock edge):
  - data_out=0, valid_out=0, chan_out=0, internal round-robin pointer ptr=0.
  - Outputs stay at these values while reset_L=0.
  - The first capture happens on the first rising edge with reset_L=1.
- Latency: one cycle. Inputs sampled on rising edge N appear on the outputs after edge N. There is no combinational path from inputs to outputs.
- hold=1 at an edge: data_out, valid_out, chan_out and ptr all retain their values. hold has priority over mode and the data inputs. Reset has priority over hold.
- mode=0 (external select):
  - sel_in < CHANNELS: data_out <= channel sel_in; chan_out <= sel_in; valid_out <= in_valid[sel_in].
  - If in_valid[sel_in]=0, data_out is still loaded with channel sel_in's data but valid_out=0.
  - sel_in ≥ CHANNELS (only possible when CHANNELS is not a power of two): data_out <= 0, valid_out <= 0, chan_out <= sel_in.
  - ptr is not modified in mode 0.
- mode=1 (round-robin):
  - Search order is ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1, wrapping modulo CHANNELS.
  - First channel g in that order with in_valid[g]=1 is granted: data_out <= channel g; chan_out <= g; valid_out <= 1; ptr <= (g+1) mod CHANNELS.
  - Wrap case: g = CHANNELS-1 gives ptr=0.
  - No valid channel: valid_out <= 0, data_out <= 0, chan_out unchanged, ptr unchanged.
  - Single valid channel held continuously: it is granted every cycle.
  - All channels valid: grants rotate 0,1,…,CHANNELS-1,0,… (starting from ptr).
- Mode change takes effect at the same edge it is sampled. Switching 0→1 resumes from the retained ptr.
- Simultaneous hold=1 and mode change: hold wins; nothing changes.
- No state beyond the output registers and ptr.

Test Plan:
- CHANNELS=4, WIDTH=2. Assert reset_L=0 mid-cycle after outputs are nonzero -> data_out=0, valid_out=0, chan_out=0 immediately, before any clk edge.
- mode=0, in_data={3,2,1,0} (channel 3 to channel 0), in_valid=4'b1111, sel_in stepping 0..3 -> one cycle later data_out steps 0,1,2,3; chan_out matches sel_in; valid_out=1.
- mode=1, in_valid=4'b1111, data as above, from reset -> chan_out sequence 0,1,2,3,0; ptr wraps to 0 after the grant to channel 3.
- mode=1, in_valid=4'b1010, ptr=0 -> grants 1,3,1,3. Then in_valid=0 for one cycle -> valid_out=0, data_out=0, chan_out holds 3; the next grant is 1.
- hold=1 for 3 cycles during round-robin with in_valid=4'b1111 -> outputs frozen. After hold=0, the rotation continues from the frozen ptr with no skipped channel.
- CHANNELS=3, mode=0, sel_in=3 -> valid_out=0, data_out=0. mode=0 with sel_in=1 and in_valid[1]=0 -> data_out=channel 1 data, valid_out=0.
